// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send, then shifts out
// eight data bits, odd parity and stop on device-generated clock falling edges, and finally
// checks the device ACK. Any stalled wait on the device aborts with an err pulse.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned MaxCycles =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StInhibit = 3'd1;
  localparam logic [2:0] StRts     = 3'd2;
  localparam logic [2:0] StSend    = 3'd3;
  localparam logic [2:0] StAck     = 3'd4;
  localparam logic [2:0] StRecover = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;
  localparam logic [2:0] StErr     = 3'd7;

  // Index of the last frame bit driven in SEND (parity); stop is the released line in ACK.
  localparam logic [3:0] LastSendIdx = 4'd8;

  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            data_meta_q, data_sync_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [8:0]      frame_q, frame_d;

  logic clk_fall;
  logic timed_out;

  assign clk_fall  = clk_prev_q & ~clk_sync_q;
  assign timed_out = (cnt_q == TimeoutLast);

  // Two-flop synchronizers; clk_prev_q holds the previous synchronized clock for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Control state, shared inhibit/timeout counter, bit index and captured frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
    end
  end

  // Next-state logic; the counter restarts on every state change and every device clock edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          frame_d = {~^tx_data, tx_data};
          cnt_d   = '0;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d   = '0;
          state_d = StRts;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRts: begin
        if (clk_fall) begin
          bit_idx_d = '0;
          cnt_d     = '0;
          state_d   = StSend;
        end else if (timed_out) begin
          cnt_d   = '0;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSend: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (bit_idx_q == LastSendIdx) begin
            state_d = StAck;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else if (timed_out) begin
          cnt_d   = '0;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAck: begin
        if (clk_fall) begin
          cnt_d   = '0;
          state_d = data_sync_q ? StErr : StRecover;
        end else if (timed_out) begin
          cnt_d   = '0;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRecover: begin
        if (clk_sync_q && data_sync_q) begin
          cnt_d   = '0;
          state_d = StDone;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (timed_out) begin
          cnt_d   = '0;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone, StErr: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line drivers and status decode straight from state so reset releases them immediately.
  always_comb begin
    ps2_clk_low  = (state_q == StInhibit);
    ps2_data_low = 1'b0;
    if (state_q == StRts) begin
      ps2_data_low = 1'b1;
    end else if (state_q == StSend) begin
      ps2_data_low = ~frame_q[bit_idx_q];
    end
    busy = (state_q == StInhibit) || (state_q == StRts) || (state_q == StSend) ||
           (state_q == StAck) || (state_q == StRecover);
    done = (state_q == StDone);
    err  = (state_q == StErr);
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clk cycles PS2 clock is held low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum clk cycles spent waiting on any device edge before abort.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  sensed level of PS2 clock line (asynchronous).
REQ-006 SHALL have port ps2_data  input  1  sensed level of PS2 data line (asynchronous).
REQ-007 SHALL have port ps2_clk_low  output  1  1 = pull PS2 clock low (open-drain enable), 0 = release.
REQ-008 SHALL have port ps2_data_low  output  1  1 = pull PS2 data low, 0 = release.
REQ-009 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-010 SHALL have port tx_start  input  1  single-cycle request; tx_data is captured in the same cycle.
REQ-011 SHALL have port busy  output  1  high from the cycle after accepted tx_start until DONE/ERR is entered.
REQ-012 SHALL have port done  output  1  one-cycle pulse: byte sent and acknowledged.
REQ-013 SHALL have port err  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-014 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer; falling edge of ps2_clk = synchronized previous 1, current 0.
REQ-015 SHALL implement states IDLE, INHIBIT, RTS, SEND, ACK, RECOVER, DONE, ERR.
REQ-016 IDLE: both lines released, busy 0; tx_start=1 captures tx_data and odd parity bit (~^tx_data), goes to INHIBIT; tx_start while busy is ignored.
REQ-017 INHIBIT: ps2_clk_low=1, data released, for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-018 RTS: ps2_data_low=1 (start bit), ps2_clk_low=0; on first ps2_clk falling edge drive bit 0 and go to SEND.
REQ-019 SEND: on each further falling edge present next bit: D1..D7, parity, then stop (data released); ps2_data_low = inverse of current bit; 4-bit index counter.
REQ-020 After the falling edge that presents stop, SHALL go to ACK; on next falling edge sample synchronized data: 0 -> RECOVER, 1 -> ERR.
REQ-021 RECOVER: wait until synchronized clk and data both 1, then DONE.
REQ-022 DONE and ERR SHALL last one cycle each, assert done/err respectively, release both lines, return to IDLE.
REQ-023 Timeout counter SHALL clear on each state entry and each ps2_clk falling edge; reaching TIMEOUT_CYCLES in RTS, SEND, ACK or RECOVER -> ERR.
REQ-024 ps2_clk_low and ps2_data_low SHALL never both be driven except in transition INHIBIT->RTS (data asserted before clock released, same cycle permitted).
REQ-025 Counter widths SHALL be derived to hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES) without wrap.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, ps2_clk_low=0, ps2_data_low=0, busy=0, done=0, err=0, counters and synchronizers cleared (sync flops to 1).
REQ-027 Reset mid-transfer SHALL abort silently (no done/err pulse) and release both lines.

Verification
REQ-028 tx_data=0xED, device model clocks 11 falling edges, ACK low -> bits 1,0,1,1,0,1,1,1, parity 1, stop released; done pulses once; busy low after.
REQ-029 tx_data=0x01 -> parity bit 0 observed; tx_data=0x00 -> parity bit 1.
REQ-030 INHIBIT_CYCLES=10: ps2_clk_low high exactly 10 cycles, then ps2_data_low=1 with ps2_clk_low=0.
REQ-031 Device never clocks, TIMEOUT_CYCLES=100 -> err pulse 100 cycles after RTS entry, lines released.
REQ-032 Device leaves data high on ACK edge -> err pulse, no done.
REQ-033 rst pulsed low during SEND bit 4 -> all outputs 0 immediately; next tx_start performs full clean transfer.
